// File: rtl/nbit_down_timer_if.sv
// Control/status bundle for nbit_down_timer: load, start/stop and count-enable in, count and flags out.
// The master drives the controls; the slave (the timer) returns DOUT, TC and BUSY.
interface nbit_down_timer_if #(
    parameter int SIZE = 8
);
    logic            CE;
    logic            LD;
    logic [SIZE-1:0] LDVAL;
    logic            START;
    logic            STOP;
    logic            AUTO;
    logic [SIZE-1:0] DOUT;
    logic            TC;
    logic            BUSY;

    modport master (
        output CE, LD, LDVAL, START, STOP, AUTO,
        input  DOUT, TC, BUSY
    );

    modport slave (
        input  CE, LD, LDVAL, START, STOP, AUTO,
        output DOUT, TC, BUSY
    );
endinterface

// File: rtl/nbit_down_timer.sv
// Loadable down-counter / interval timer with one-shot or auto-reload terminal count.
// Optional CE prescaler enabled by defining NBIT_DOWN_TIMER_PRESCALE_EN (adds parameter PRESCALE).
module nbit_down_timer #(
    parameter int SIZE = 8
`ifdef NBIT_DOWN_TIMER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input logic           CLK,
    input logic           RST_N,
    nbit_down_timer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    state_e          state_q, state_d;
    logic [SIZE-1:0] dout_q, dout_d;
    logic [SIZE-1:0] rld_q, rld_d;
    logic            tc_q, tc_d;
    logic            en_tick;

`ifdef NBIT_DOWN_TIMER_PRESCALE_EN
    localparam int              DIV_W    = $clog2(PRESCALE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] div_q, div_d;

    // Only the last CE cycle of each PRESCALE-long group is a real decrement.
    assign en_tick = bus.CE && (div_q == DIV_LAST);
`else
    assign en_tick = bus.CE;
`endif

    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
`ifdef NBIT_DOWN_TIMER_PRESCALE_EN
        div_d   = div_q;
`endif

        if (bus.LD) begin
            dout_d  = bus.LDVAL;
            rld_d   = bus.LDVAL;
            state_d = (bus.LDVAL != '0) ? ST_RUN : ST_IDLE;
`ifdef NBIT_DOWN_TIMER_PRESCALE_EN
            div_d   = '0;
`endif
        end else if (bus.STOP) begin
            if (state_q == ST_RUN) begin
                state_d = (dout_q == '0) ? ST_IDLE : ST_PAUSE;
            end
        end else if (bus.START) begin
`ifdef NBIT_DOWN_TIMER_PRESCALE_EN
            div_d = '0;
`endif
            case (state_q)
                ST_PAUSE: state_d = ST_RUN;
                ST_IDLE: begin
                    // Retrigger from the last loaded value; a zero reload means nothing to time.
                    if (rld_q != '0) begin
                        dout_d  = rld_q;
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end else if ((state_q == ST_RUN) && bus.CE) begin
`ifdef NBIT_DOWN_TIMER_PRESCALE_EN
            div_d = en_tick ? '0 : div_q + 1'b1;
`endif
            if (en_tick) begin
                if (dout_q > ONE) begin
                    dout_d = dout_q - ONE;
                end else if (dout_q == ONE) begin
                    tc_d = 1'b1;
                    if (bus.AUTO) begin
                        dout_d = rld_q;
                    end else begin
                        dout_d  = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    // A zero count while running cannot arise from normal use; park safely.
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            rld_q   <= '0;
            tc_q    <= 1'b0;
`ifdef NBIT_DOWN_TIMER_PRESCALE_EN
            div_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            rld_q   <= rld_d;
            tc_q    <= tc_d;
`ifdef NBIT_DOWN_TIMER_PRESCALE_EN
            div_q   <= div_d;
`endif
        end
    end

    assign bus.DOUT = dout_q;
    assign bus.TC   = tc_q;
    assign bus.BUSY = (state_q == ST_RUN);

endmodule
